// File: rtl/tawas_dbus_ram_if.sv
// tawas_dbus_ram_if: data-bus request/response bundle between an initiator and tawas_dbus_ram.
interface tawas_dbus_ram_if;
  logic        dcs;
  logic        dwr;
  logic [31:0] daddr;
  logic [3:0]  dmask;
  logic [31:0] dout;
  logic [31:0] din;
  logic        derr;
  logic        wbuf_busy;
  logic [15:0] err_count;
  modport master (output dcs, dwr, daddr, dmask, dout, input din, derr, wbuf_busy, err_count);
  modport slave (input dcs, dwr, daddr, dmask, dout, output din, derr, wbuf_busy, err_count);
endinterface

// File: rtl/tawas_dbus_ram.sv
// tawas_dbus_ram: single-port data RAM with a one-entry coalescing write buffer and load forwarding.
module tawas_dbus_ram #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input logic             clk,
  input logic             rst,
  tawas_dbus_ram_if.slave bus
);
  localparam int IW = DEPTH_LOG2;
  logic [31:0]   mem [2**IW];
  logic [31:0]   off, st_data, din_w;
  logic [IW-1:0] idx;
  logic          in_win, ld_req, ld, st, same, retire;
  logic          wb_vld_q, wb_vld_d;
  logic [IW-1:0] wb_idx_q, wb_idx_d;
  logic [3:0]    wb_mask_q, wb_mask_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [3:0]    fwd_mask_q;
  logic [31:0]   fwd_data_q, rd_q;
  logic          derr_q;
  logic [15:0]   err_count_q;
  assign off    = bus.daddr - ADDR_BASE;
  assign in_win = bus.daddr >= ADDR_BASE && (off >> (IW + 2)) == 32'd0;
  assign idx    = IW'(off >> 2);
  assign ld_req = bus.dcs && !bus.dwr;
  assign ld     = ld_req && in_win;
  assign st     = bus.dcs && bus.dwr && in_win && bus.dmask != 4'd0;
  assign same   = wb_vld_q && wb_idx_q == idx;
  // Any cycle without a load request frees the array, except a coalescing store.
  assign retire = wb_vld_q && !ld_req && !(st && same);
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign st_data[8*i+:8] = (same && !bus.dmask[i]) ? wb_data_q[8*i+:8] : bus.dout[8*i+:8];
    assign din_w[8*i+:8]   = fwd_mask_q[i] ? fwd_data_q[8*i+:8] : rd_q[8*i+:8];
  end
  assign wb_vld_d  = st || (wb_vld_q && !retire);
  assign wb_idx_d  = st ? idx : wb_idx_q;
  assign wb_mask_d = st ? (same ? wb_mask_q | bus.dmask : bus.dmask) : wb_mask_q;
  assign wb_data_d = st ? st_data : wb_data_q;
  always_ff @(posedge clk) begin
    if (retire)
      for (int i = 0; i < 4; i++)
        if (wb_mask_q[i]) mem[wb_idx_q][8*i+:8] <= wb_data_q[8*i+:8];
    if (ld) rd_q <= mem[idx];
  end
  // An all-ones forward mask with zero data yields din=0 on reset and out-of-window loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_vld_q    <= 1'b0;
      wb_idx_q    <= '0;
      wb_mask_q   <= '0;
      wb_data_q   <= '0;
      fwd_mask_q  <= 4'hF;
      fwd_data_q  <= '0;
      derr_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      wb_vld_q  <= wb_vld_d;
      wb_idx_q  <= wb_idx_d;
      wb_mask_q <= wb_mask_d;
      wb_data_q <= wb_data_d;
      if (ld_req) begin
        fwd_mask_q <= ld ? (same ? wb_mask_q : 4'd0) : 4'hF;
        fwd_data_q <= ld ? wb_data_q : 32'd0;
      end
      derr_q <= bus.dcs && !in_win;
      if (bus.dcs && !in_win && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
    end
  end
  assign bus.din       = din_w;
  assign bus.derr      = derr_q;
  assign bus.wbuf_busy = wb_vld_q;
  assign bus.err_count = err_count_q;
endmodule

// File: doc/tawas_dbus_ram.md
TAWAS_DBUS_RAM -- requirements
Module: tawas_dbus_ram

Interface
REQ-001 The block SHALL have parameter ADDR_BASE, default 32'h0000_0000, byte address of the RAM window (word aligned).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 10, log2 of the word count (1024 x 32-bit words).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port dcs  input  1  data-bus request valid, one cycle per request.
REQ-006 The block SHALL have port dwr  input  1  1 = store, 0 = load; qualified by dcs.
REQ-007 The block SHALL have port daddr  input  32  byte address; bits [1:0] ignored.
REQ-008 The block SHALL have port dmask  input  4  byte enables for stores; bit i selects bits [8i+7:8i].
REQ-009 The block SHALL have port dout  input  32  store data from the initiator.
REQ-010 The block SHALL have port din  output  32  load data returned to the initiator.
REQ-011 The block SHALL have port derr  output  1  one-cycle pulse flagging an out-of-window access.
REQ-012 The block SHALL have port wbuf_busy  output  1  write buffer holds an unretired store.
REQ-013 The block SHALL have port err_count  output  16  saturating count of out-of-window accesses.

Function
REQ-014 A request is in-window when ADDR_BASE <= daddr < ADDR_BASE + 4*2^DEPTH_LOG2; word index = (daddr - ADDR_BASE) >> 2.
REQ-015 Storage SHALL be one single-port array of 2^DEPTH_LOG2 x 32 bits, with at most one access (read or write) per cycle.
REQ-016 Load in cycle N: din SHALL present the word in cycle N+1, registered; fixed latency 1, no stall.
REQ-017 din SHALL hold its value until the next load completes.
REQ-018 Store in cycle N SHALL be captured into a one-entry write buffer (index, 4-bit mask, 32-bit data); wbuf_busy=1 from N+1.
REQ-019 Store with dmask=4'b0000 SHALL be accepted with no effect on buffer or array.
REQ-020 Retirement: a buffered store SHALL write its masked bytes to the array in any cycle where the array is not read, i.e. dcs=0, or dcs=1 with dwr=1.
REQ-021 Loads SHALL take array priority; a pending store stays buffered across back-to-back loads without limit.
REQ-022 New store to a different index while the buffer is busy: the old entry retires and the new one is captured in the same cycle.
REQ-023 New store to the same index while the buffer is busy: the entry SHALL coalesce (mask |= dmask; masked bytes replaced by dout), with no array write.
REQ-024 Load hitting the buffered index: each byte of din SHALL come from the buffer where the buffer mask bit is set, else from the array (forwarding).
REQ-025 Load and store are never simultaneous (one request per cycle); dwr is ignored when dcs=0.
REQ-026 Out-of-window load: din SHALL be 32'h0000_0000 in N+1 and derr=1 in N+1.
REQ-027 Out-of-window store: the store SHALL be dropped, with derr=1 in N+1 and the buffer unchanged (it may still retire that cycle per REQ-020).
REQ-028 err_count SHALL increment once per derr pulse and saturate at 16'hFFFF.

Reset
REQ-029 While rst=0: din=0, derr=0, wbuf_busy=0, err_count=0, write buffer invalid; array contents are not initialised.
REQ-030 Reset assertion SHALL take effect immediately and asynchronously; a buffered unretired store SHALL be discarded.
REQ-031 Deassertion SHALL be synchronised by the integrator; the first request is honoured on the first rising edge with rst=1.

Verification
REQ-032 Store 0x4 data 0x11223344 mask 1111, then load 0x4 the next cycle -> din=0x11223344 via forwarding; wbuf_busy stays 1 and retires on the first idle cycle.
REQ-033 Word 2=0xAABBCCDD; store 0x8 mask 0101 data 0x00550066, then load 0x8 -> din=0xAA55CC66.
REQ-034 Store 0x10 mask 0001 data 0x000000EE, then store 0x10 mask 1000 data 0xFF000000 (coalesce), idle, load 0x10 -> bytes 3 and 0 = FF/EE, middle bytes unchanged from the array.
REQ-035 With ADDR_BASE=0x1000 and DEPTH_LOG2=10, load 0x2000 -> din=0, derr one cycle, err_count=1; store 0x0FFC -> dropped, err_count=2.
REQ-036 Store pending, then 50 back-to-back loads to other indices, then idle -> the array write occurs only in the idle cycle, and a later load returns the stored data.
REQ-037 Store pending, then rst=0 for one cycle mid-stream -> all outputs 0, wbuf_busy=0, and the array word is unchanged by the discarded store.
